// File: rtl/word_tx.sv
// word_tx: serializes WIDTH-bit words LSB byte first into a byte UART with XON/XOFF pausing
module word_tx #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             stb_i,
  output logic             rdy_o,
  input  logic             xon_i,
  input  logic             xoff_i,
  output logic [7:0]       byte_o,
  output logic             byte_stb_o,
  input  logic             byte_rdy_i,
  output logic             paused_o
);
  localparam int NBYTES = WIDTH / 8;
  localparam int CW = $clog2(NBYTES + 1);
  localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2;
  logic [1:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic             paused;
  logic             fire;
  assign fire = (state == SEND) && byte_rdy_i && !paused;
  assign rdy_o = (state == IDLE);
  assign paused_o = paused;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      sreg       <= '0;
      cnt        <= '0;
      paused     <= 1'b0;
      byte_o     <= 8'h00;
      byte_stb_o <= 1'b0;
    end else begin
      // xoff dominates a simultaneous xon
      paused     <= xoff_i | (paused & ~xon_i);
      byte_stb_o <= fire;
      if (fire) begin
        byte_o <= sreg[7:0];
        sreg   <= sreg >> 8;
        cnt    <= cnt + 1'b1;
      end
      if (state == IDLE && stb_i) begin
        sreg <= data_i;
        cnt  <= '0;
      end
      state <= (state == IDLE) ? (stb_i ? SEND : IDLE) :
               (state == SEND) ? (fire ? GAP : SEND) :
               (state == GAP)  ? ((cnt == CW'(NBYTES)) ? IDLE : SEND) : IDLE;
    end
  end
endmodule

// File: tb/tb_word_tx.sv
// tb_word_tx: scoreboard bench for word_tx; stimulus queues expected bytes, a monitor pops them
module tb_word_tx;
  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] data_i = '0;
  logic        stb_i = 1'b0;
  logic        rdy_o;
  logic        xon_i = 1'b0;
  logic        xoff_i = 1'b0;
  logic [7:0]  byte_o;
  logic        byte_stb_o;
  logic        byte_rdy_i = 1'b1;
  logic        paused_o;

  word_tx #(.WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .data_i(data_i), .stb_i(stb_i), .rdy_o(rdy_o),
    .xon_i(xon_i), .xoff_i(xoff_i), .byte_o(byte_o), .byte_stb_o(byte_stb_o),
    .byte_rdy_i(byte_rdy_i), .paused_o(paused_o)
  );

  always #5 clk = ~clk;

  logic [7:0] sb[$];
  int n_pass = 0, n_tot = 0, n_stb = 0, busy = 0, blen = 0, base;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, got, exp, $time);
  endtask

  // Monitor and UART model share one block so the busy flag it checks is the one the DUT sampled
  always @(negedge clk) begin
    if (byte_stb_o) begin
      n_stb++;
      check("stb_while_uart_busy", {31'd0, byte_rdy_i}, 32'd1);
      if (sb.size() == 0) check("unexpected_strobe", {24'd0, byte_o}, 32'hFFFF_FFFF);
      else check("byte_value", {24'd0, byte_o}, {24'd0, sb.pop_front()});
      busy = blen;
    end else if (busy > 0) busy--;
    byte_rdy_i = (busy == 0);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input bit push);
    for (int i = 0; i < 500 && !rdy_o; i++) tick;
    check("send_rdy_timeout", {31'd0, rdy_o}, 32'd1);
    stb_i = 1'b1;
    data_i = w;
    if (push) for (int k = 0; k < 4; k++) sb.push_back(w[8*k +: 8]);
    tick;
    stb_i = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 600 && (sb.size() != 0 || !rdy_o); i++) tick;
    check("drain_queue", sb.size(), 0);
    check("drain_rdy", {31'd0, rdy_o}, 32'd1);
  endtask

  task automatic wait_stb(input int target);
    for (int i = 0; i < 500 && n_stb < target; i++) tick;
    check("wait_strobe", n_stb, target);
  endtask

  task automatic pulse(input bit on, input bit off);
    xon_i = on;
    xoff_i = off;
    tick;
    xon_i = 1'b0;
    xoff_i = 1'b0;
  endtask

  initial begin
    tick;
    check("rst_rdy", {31'd0, rdy_o}, 32'd1);
    check("rst_byte", {24'd0, byte_o}, 32'h00);
    check("rst_stb", {31'd0, byte_stb_o}, 32'd0);
    check("rst_paused", {31'd0, paused_o}, 32'd0);
    rst_i = 1'b0;
    tick;
    // ideal UART: strobes at cycles 2/4/6/8, rdy_o back in cycle 9
    send(32'hA1B2C3D4, 1'b1);
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("t1_stb_c%0d", k), {31'd0, byte_stb_o}, {31'd0, (k % 2 == 0) && (k <= 8)});
      check($sformatf("t1_rdy_c%0d", k), {31'd0, rdy_o}, {31'd0, k == 9});
      @(posedge clk);
      #1;
    end
    drain;
    // slow UART, back-to-back words
    blen = 10;
    base = n_stb;
    send(32'h00000001, 1'b1);
    send(32'h80000000, 1'b1);
    drain;
    check("t2_count", n_stb - base, 8);
    // xoff after first byte holds the rest until xon
    base = n_stb;
    send(32'h44332211, 1'b1);
    wait_stb(base + 1);
    pulse(1'b0, 1'b1);
    repeat (50) tick;
    check("t3_paused", {31'd0, paused_o}, 32'd1);
    check("t3_one_sent", n_stb - base, 1);
    check("t3_pending", sb.size(), 3);
    pulse(1'b1, 1'b0);
    drain;
    check("t3_resumed", {31'd0, paused_o}, 32'd0);
    check("t3_count", n_stb - base, 4);
    // xon and xoff together while idle: xoff wins, word is accepted but held
    blen = 0;
    base = n_stb;
    pulse(1'b1, 1'b1);
    check("t4_paused", {31'd0, paused_o}, 32'd1);
    send(32'h12345678, 1'b1);
    check("t4_accepted", {31'd0, rdy_o}, 32'd0);
    repeat (20) tick;
    check("t4_held", sb.size(), 4);
    check("t4_no_strobe", n_stb - base, 0);
    pulse(1'b1, 1'b0);
    drain;
    check("t4_resumed", {31'd0, paused_o}, 32'd0);
    // strobe while a word is in flight is ignored
    blen = 10;
    base = n_stb;
    send(32'h0badf00d, 1'b1);
    stb_i = 1'b1;
    data_i = 32'hFFFFFFFF;
    repeat (20) tick;
    stb_i = 1'b0;
    check("t5_busy", {31'd0, rdy_o}, 32'd0);
    drain;
    check("t5_count", n_stb - base, 4);
    // asynchronous reset mid-word drops the rest and clears pause
    base = n_stb;
    send(32'hCAFEBABE, 1'b1);
    wait_stb(base + 2);
    pulse(1'b0, 1'b1);
    check("t6_paused", {31'd0, paused_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check("t6_rst_stb", {31'd0, byte_stb_o}, 32'd0);
    check("t6_rst_byte", {24'd0, byte_o}, 32'h00);
    check("t6_rst_rdy", {31'd0, rdy_o}, 32'd1);
    check("t6_rst_paused", {31'd0, paused_o}, 32'd0);
    sb.delete();
    tick;
    rst_i = 1'b0;
    repeat (30) tick;
    check("t6_silent", n_stb - base, 2);
    blen = 0;
    send(32'h5A0F3C96, 1'b1);
    drain;
    check("t6_recover", n_stb - base, 6);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
